sqd_sched: RTL and testbench
============================

SQD_SCHED -- requirements
Module: sqd_sched

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide ports: req0, req1  input  1  word-scan request from requester 0 / 1.
REQ-004 SHALL provide ports: data0, data1  input  8  word to scan; requester holds it stable while its req is high.
REQ-005 SHALL provide ports: gnt0, gnt1  output  1  one-cycle grant pulse; requester deasserts req after seeing it.
REQ-006 SHALL provide port: det_rst  output  1  reset to the attached sequence detector.
REQ-007 SHALL provide port: det_inp  output  1  serial bit driven into the detector input.
REQ-008 SHALL provide port: det_w  input  1  detector match output, Moore-type.
REQ-009 SHALL provide ports: busy  output  1  high in every state except IDLE.
REQ-010 SHALL provide ports: cnt  output  4  match count; cnt_src  output  1  requester served; cnt_vld  output  1  one-cycle result strobe.

Function
REQ-011 SHALL implement FSM states IDLE, CLR, SHIFT, DRAIN, REPORT.
REQ-012 IDLE: no req -> stay; any req -> on the edge, capture the winner's data into an 8-bit shift register, latch src, go to CLR.
REQ-013 Arbitration SHALL be round-robin on last-served pointer lp: single req wins; both high -> grant requester !lp.
REQ-014 CLR (1 cycle): gnt[src]=1, det_rst=1, match counter cleared; -> SHIFT with bit index 0.
REQ-015 SHIFT (8 cycles, index 0..7): det_inp = shift-register MSB; shift left each edge; index 7 -> DRAIN.
REQ-016 Word bits SHALL be sent MSB first (data[7] in index 0, data[0] in index 7).
REQ-017 Counter SHALL increment on each edge where det_w=1 and state is SHIFT index 1..7 or DRAIN (8 samples, one after each bit).
REQ-018 Counter SHALL be 4 bits; maximum reachable value 8, no wrap.
REQ-019 DRAIN (1 cycle): det_inp=0; -> REPORT.
REQ-020 REPORT (1 cycle): cnt_vld=1, cnt and cnt_src updated with the result, lp<=src; -> IDLE.
REQ-021 Latency: cnt_vld SHALL assert exactly 11 cycles after the capture edge (CLR 1 + SHIFT 8 + DRAIN 1 + REPORT).
REQ-022 cnt and cnt_src SHALL hold their value between REPORT cycles.
REQ-023 det_inp SHALL be 0 outside SHIFT; det_rst SHALL be 0 outside CLR except during rst.
REQ-024 req changes while busy SHALL be ignored; a req still high in IDLE is arbitrated normally.
REQ-025 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-026 rst high SHALL immediately force: state=IDLE, lp=1 (req0 wins the first tie), counter=0, cnt=0, cnt_src=0, cnt_vld=0, gnt0=gnt1=0, det_inp=0, busy=0.
REQ-027 det_rst SHALL equal 1 while rst is high (combinational OR with the CLR decode).
REQ-028 rst mid-operation SHALL abort the scan with no cnt_vld and no gnt; the next req starts a fresh scan.

Verification
REQ-029 req0=1, data0=8'hFF, det_w tied 1 -> gnt0 pulse 1 cycle after capture, cnt_vld at +11, cnt=8, cnt_src=0.
REQ-030 Bench detector model (w=1 after two consecutive 1s), data1=8'hFF via req1 -> cnt=7, cnt_src=1; with data1=8'hAA -> cnt=0.
REQ-031 req0=req1=1 held from reset -> grants alternate gnt0, gnt1, gnt0, ... ; cnt_src alternates 0,1,0.
REQ-032 det_inp trace for data0=8'hB4 -> 1,0,1,1,0,1,0,0 across SHIFT index 0..7; det_rst high only in CLR.
REQ-033 rst pulse during SHIFT index 4 -> all outputs at reset values, no cnt_vld; later req0 with det_w=0 -> cnt=0 at +11.
REQ-034 req1 asserted while busy serving req0 -> no gnt1 until IDLE; gnt1 exactly 1 cycle after the first REPORT returns to IDLE and captures.

Source files
------------

// File: rtl/sqd_sched.sv
// Round-robin word-scan scheduler: serialises an 8-bit word MSB-first into an
// external sequence detector and reports how many cycles its match output was high.
module sqd_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       det_rst,
    output logic       det_inp,
    input  logic       det_w,
    output logic       busy,
    output logic [3:0] cnt,
    output logic       cnt_src,
    output logic       cnt_vld
);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, REPORT} state_t;

    state_t     state_reg, state_next;
    logic [7:0] sr_reg, sr_next;
    logic [2:0] idx_reg, idx_next;
    logic       src_reg, src_next;
    logic       lp_reg, lp_next;
    logic [3:0] mcnt_reg, mcnt_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       cnt_src_reg, cnt_src_next;
    logic       cnt_vld_reg, cnt_vld_next;
    logic       win;
    logic [1:0] gnt_vec;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign win = req1 & (~req0 | ~lp_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            sr_reg      <= '0;
            idx_reg     <= '0;
            src_reg     <= 1'b0;
            lp_reg      <= 1'b1;
            mcnt_reg    <= '0;
            cnt_reg     <= '0;
            cnt_src_reg <= 1'b0;
            cnt_vld_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sr_reg      <= sr_next;
            idx_reg     <= idx_next;
            src_reg     <= src_next;
            lp_reg      <= lp_next;
            mcnt_reg    <= mcnt_next;
            cnt_reg     <= cnt_next;
            cnt_src_reg <= cnt_src_next;
            cnt_vld_reg <= cnt_vld_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sr_next      = sr_reg;
        idx_next     = idx_reg;
        src_next     = src_reg;
        lp_next      = lp_reg;
        mcnt_next    = mcnt_reg;
        cnt_next     = cnt_reg;
        cnt_src_next = cnt_src_reg;
        cnt_vld_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req0 | req1) begin
                    src_next   = win;
                    sr_next    = win ? data1 : data0;
                    state_next = CLR;
                end
            end
            CLR: begin
                mcnt_next  = '0;
                idx_next   = '0;
                state_next = SHIFT;
            end
            SHIFT: begin
                sr_next  = {sr_reg[6:0], 1'b0};
                idx_next = idx_reg + 3'd1;
                // Moore detector lags one cycle, so index 0 carries no result yet.
                if (idx_reg != 3'd0 && det_w && mcnt_reg < 4'd8)
                    mcnt_next = mcnt_reg + 4'd1;
                if (idx_reg == 3'd7)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (det_w && mcnt_reg < 4'd8)
                    mcnt_next = mcnt_reg + 4'd1;
                state_next = REPORT;
            end
            REPORT: begin
                cnt_vld_next = 1'b1;
                cnt_next     = mcnt_reg;
                cnt_src_next = src_reg;
                lp_next      = src_reg;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt_vec[gi] = (state_reg == CLR) && (src_reg == 1'(gi));
        end
    endgenerate

    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];
    assign det_rst = rst | (state_reg == CLR);
    assign det_inp = (state_reg == SHIFT) & sr_reg[7];
    assign busy    = (state_reg != IDLE);
    assign cnt     = cnt_reg;
    assign cnt_src = cnt_src_reg;
    assign cnt_vld = cnt_vld_reg;

endmodule

// File: tb/tb_sqd_sched.sv
// Directed bench for sqd_sched with a "two consecutive ones" Moore detector model
// that can be overridden by a constant match level.
module tb_sqd_sched;

    logic       clk, rst, req0, req1, det_w;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, det_rst, det_inp, busy, cnt_src, cnt_vld;
    logic [3:0] cnt;

    logic       tie_en, tie_val;
    logic [1:0] det_s;
    int         n_assert = 0;
    int         n_fail = 0;

    sqd_sched dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
        .det_rst(det_rst), .det_inp(det_inp), .det_w(det_w),
        .busy(busy), .cnt(cnt), .cnt_src(cnt_src), .cnt_vld(cnt_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (det_rst)
            det_s <= 2'd0;
        else if (det_inp)
            det_s <= (det_s == 2'd2) ? 2'd2 : det_s + 2'd1;
        else
            det_s <= 2'd0;
    end
    assign det_w = tie_en ? tie_val : (det_s == 2'd2);

    task automatic chk(input string tag, input string what,
                       input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s %s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    // Starts at a falling edge, ends at the falling edge where cnt_vld is expected.
    task automatic scan(input bit r0, input bit r1, input bit hold, input bit raise1,
                        input bit exp_src, input logic [7:0] word,
                        input logic [3:0] exp_cnt, input string tag);
        req0 = r0;
        req1 = r1;
        @(negedge clk);
        chk(tag, "gnt0", gnt0, exp_src == 1'b0);
        chk(tag, "gnt1", gnt1, exp_src == 1'b1);
        chk(tag, "det_rst_clr", det_rst, 1'b1);
        chk(tag, "busy_clr", busy, 1'b1);
        if (!hold) begin
            if (exp_src) req1 = 1'b0;
            else         req0 = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (raise1 && k == 1) req1 = 1'b1;
            chk(tag, $sformatf("det_inp[%0d]", k), det_inp, word[7-k]);
            chk(tag, $sformatf("gnt_shift[%0d]", k), gnt0 | gnt1, 1'b0);
            chk(tag, $sformatf("det_rst_shift[%0d]", k), det_rst, 1'b0);
        end
        @(negedge clk);
        chk(tag, "det_inp_drain", det_inp, 1'b0);
        chk(tag, "busy_drain", busy, 1'b1);
        @(negedge clk);
        chk(tag, "cnt_vld_early", cnt_vld, 1'b0);
        @(negedge clk);
        chk(tag, "cnt_vld", cnt_vld, 1'b1);
        chk(tag, "cnt", cnt, exp_cnt);
        chk(tag, "cnt_src", cnt_src, exp_src);
        chk(tag, "busy_done", busy, 1'b0);
        $display("scan %s: src=%0d cnt=%0d", tag, cnt_src, cnt);
    endtask

    initial begin
        bit seen_vld, seen_busy;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        data0 = 8'hFF; data1 = 8'hFF;
        tie_en = 1'b1; tie_val = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset", "busy", busy, 1'b0);
        chk("reset", "gnt0", gnt0, 1'b0);
        chk("reset", "gnt1", gnt1, 1'b0);
        chk("reset", "det_inp", det_inp, 1'b0);
        chk("reset", "det_rst", det_rst, 1'b1);
        chk("reset", "cnt", cnt, 4'd0);
        chk("reset", "cnt_src", cnt_src, 1'b0);
        chk("reset", "cnt_vld", cnt_vld, 1'b0);

        // Both requesters held from reset: grants alternate 0,1,0
        rst = 1'b0;
        scan(1, 1, 1, 0, 0, 8'hFF, 4'd8, "rr1");
        scan(1, 1, 1, 0, 1, 8'hFF, 4'd8, "rr2");
        scan(1, 1, 0, 0, 0, 8'hFF, 4'd8, "rr3");
        req1 = 1'b0;
        @(negedge clk);
        chk("hold", "cnt_vld", cnt_vld, 1'b0);
        chk("hold", "cnt", cnt, 4'd8);
        chk("hold", "busy", busy, 1'b0);

        scan(1, 0, 0, 0, 0, 8'hFF, 4'd8, "tied1");

        tie_en = 1'b0;
        data1 = 8'hFF;
        scan(0, 1, 0, 0, 1, 8'hFF, 4'd7, "det_ff");
        data1 = 8'hAA;
        scan(0, 1, 0, 0, 1, 8'hAA, 4'd0, "det_aa");
        data0 = 8'hB4;
        scan(1, 0, 0, 0, 0, 8'hB4, 4'd1, "trace_b4");

        // Abort in SHIFT index 4
        tie_en = 1'b1; tie_val = 1'b1;
        data0 = 8'hFF;
        req0 = 1'b1;
        @(negedge clk);
        chk("abort", "gnt0", gnt0, 1'b1);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort", "busy_pre", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("abort", "busy", busy, 1'b0);
        chk("abort", "gnt", gnt0 | gnt1, 1'b0);
        chk("abort", "det_inp", det_inp, 1'b0);
        chk("abort", "det_rst", det_rst, 1'b1);
        chk("abort", "cnt", cnt, 4'd0);
        chk("abort", "cnt_src", cnt_src, 1'b0);
        chk("abort", "cnt_vld", cnt_vld, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen_vld = 1'b0;
        seen_busy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (cnt_vld) seen_vld = 1'b1;
            if (busy)    seen_busy = 1'b1;
        end
        chk("abort", "late_cnt_vld", seen_vld, 1'b0);
        chk("abort", "late_busy", seen_busy, 1'b0);
        // Tie after reset must go to requester 0 again
        tie_val = 1'b0;
        scan(1, 1, 0, 0, 0, 8'hFF, 4'd0, "post_rst");
        req1 = 1'b0;

        // Requester 1 raised while busy: served right after the first scan
        tie_val = 1'b1;
        data0 = 8'hFF; data1 = 8'hAA;
        scan(1, 0, 0, 1, 0, 8'hFF, 4'd8, "busy0");
        scan(0, 1, 0, 0, 1, 8'hAA, 4'd8, "late1");
        req1 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
